button_step_gen: RTL and testbench
==================================

# button_step_gen

- Converts raw alarm-clock push-buttons into the single-cycle `up` / `down` / `load` command pulses consumed by the mod-N up/down time counters.
- Per button: 2-FF synchronizer, then a debouncer.
- A shared hold/auto-repeat state machine emits one step on press, then repeated steps while a direction button stays held.
- Sits between the board button pins and the hours/minutes/alarm counters.

## Interface
Parameters:
- `DB_CYCLES`, 4 — consecutive stable synchronized samples required to accept a level change (≥1).
- `HOLD_CYCLES`, 10 — cycles from first step pulse to first repeat pulse (≥2).
- `REPEAT_CYCLES`, 3 — cycles between successive repeat pulses (≥2).

Ports:
- `clk`  in  1  system clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `btn_up`  in  1  raw up button, asynchronous, active-high.
- `btn_down`  in  1  raw down button, asynchronous, active-high.
- `btn_load`  in  1  raw load/set button, asynchronous, active-high.
- `up`  out  1  one-cycle increment command.
- `down`  out  1  one-cycle decrement command.
- `load`  out  1  one-cycle load command.
- `repeating`  out  1  high while auto-repeat phase is active.

## Operation
- All outputs registered. With `reset` low: every output 0, synchronizers 0, debounced levels 0, timers 0, FSM = IDLE.
- Synchronizer: `s = sync2`, where `sync1 <= btn`, `sync2 <= sync1`.
- Debouncer (per button): `db` is the debounced level; `cnt` holds width `$clog2(DB_CYCLES+1)`.
  - `cnt` clears whenever `s == db`; otherwise it increments.
  - When `cnt` reaches `DB_CYCLES`, `db <= s` and `cnt` clears.
  - Glitches shorter than `DB_CYCLES` samples never reach `db`.
- FSM states: IDLE, HOLD_UP, HOLD_DOWN, LOCK.
- IDLE:
  - `db_up` rises alone → pulse `up`, go HOLD_UP, timer = `HOLD_CYCLES`.
  - `db_down` rises alone → symmetric, goes HOLD_DOWN.
  - `db_up` and `db_down` both high → LOCK, no pulse.
- HOLD_UP (HOLD_DOWN is symmetric):
  - Timer decrements each cycle. When it expires: pulse `up`, reload timer with `REPEAT_CYCLES`, set `repeating` = 1.
  - `db_up` falls → IDLE, `repeating` = 0, no further pulse. Takes priority over a same-cycle expiry.
  - `db_down` goes high → LOCK, no pulse.
- LOCK: no direction pulses. Exits to IDLE only when `db_up` = 0 and `db_down` = 0.
- Load, from any state:
  - A `db_load` rising edge emits one `load` pulse. No auto-repeat on load.
  - In that cycle `up`/`down` are suppressed; any pending repeat pulse is dropped.
  - Next state: LOCK if a direction `db` is high, else IDLE.
- Outputs are mutually exclusive: at most one of `up`/`down`/`load` is high per cycle.
- Timer width: `$clog2(max(HOLD_CYCLES, REPEAT_CYCLES)+1)`. The timer does not wrap; it is reloaded only on expiry or on entry to a HOLD state.

## Timing
- Press latency: count edge 1 as the first edge sampling the raw button high.
  - `db` rises at edge `DB_CYCLES+2`.
  - Pulse is high for exactly the one cycle after edge `DB_CYCLES+3`.
- Release latency: `db` falls `DB_CYCLES+2` edges after the raw fall. Pulses scheduled at or after that edge never occur.
- Hold spacing: first pulse at cycle P, repeats at `P+HOLD_CYCLES`, then every `REPEAT_CYCLES`.
- `repeating` rises with the first repeat pulse and falls the cycle after `db` falls or LOCK is entered.
- Reset mid-hold: outputs drop to 0 asynchronously. After release, a still-pressed button is treated as a fresh press, with the full latency.

## Test plan
- Reset:
  - Apply `reset` = 0 mid-repeat → all outputs 0 immediately.
  - Release with `btn_up` held → first `up` exactly 7 edges later (defaults).
- Single press: `btn_up` high for 20 cycles → one `up` pulse at edge 7, repeats at 17, 20(if still held by debounce) → verify count, each pulse exactly 1 cycle, `repeating` = 1 from edge 17.
- Bounce: `btn_down` toggling every 2 cycles for 12 cycles, then stable high → no `down` until 7 edges after stable high, exactly one pulse.
- Long hold: `btn_up` held 40 cycles → pulses at P, P+10, P+13, P+16, …. No pulse after `db_up` falls.
- Conflict:
  - `btn_down` pressed while HOLD_UP → `up` stops, no `down` pulse.
  - Release both, press `btn_down` → normal single `down`.
- Load priority: `btn_load` rising while HOLD_UP repeating → one `load` pulse, no `up` that cycle, no further `up` until `btn_up` released and re-pressed.

Source files
------------

// File: rtl/button_step_gen_if.sv
// Button pins in, step commands out: the link between the board buttons and the
// time counters.
interface button_step_gen_if;
    logic btn_up;
    logic btn_down;
    logic btn_load;
    logic up;
    logic down;
    logic load;
    logic repeating;

    // Board side drives raw buttons and consumes the command pulses.
    modport master (
        output btn_up,
        output btn_down,
        output btn_load,
        input  up,
        input  down,
        input  load,
        input  repeating
    );

    modport slave (
        input  btn_up,
        input  btn_down,
        input  btn_load,
        output up,
        output down,
        output load,
        output repeating
    );
endinterface

// File: rtl/button_step_gen.sv
// Alarm-clock push-button front end: synchronize and debounce each button, then turn
// presses into single-cycle up/down/load commands with hold-to-repeat on up/down.
module button_step_gen #(
    parameter int unsigned DB_CYCLES     = 4,
    parameter int unsigned HOLD_CYCLES   = 10,
    parameter int unsigned REPEAT_CYCLES = 3
) (
    input  logic             clk,
    input  logic             reset,
    button_step_gen_if.slave bus
);

    localparam int unsigned NumBtn   = 3;
    localparam int unsigned BtnUp    = 0;
    localparam int unsigned BtnDown  = 1;
    localparam int unsigned BtnLoad  = 2;
    localparam int unsigned CntW     = $clog2(DB_CYCLES + 1);
    localparam int unsigned TimerMax = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES
                                                                     : REPEAT_CYCLES;
    localparam int unsigned TimerW   = $clog2(TimerMax + 1);

    typedef enum logic [1:0] {StIdle, StHoldUp, StHoldDown, StLock} state_e;

    logic [NumBtn-1:0] raw;
    logic [NumBtn-1:0] sync1_d, sync1_q;
    logic [NumBtn-1:0] sync2_d, sync2_q;
    logic [NumBtn-1:0] db_d, db_q;
    logic [NumBtn-1:0] db_prev_d, db_prev_q;
    logic [CntW-1:0]   cnt_d [NumBtn];
    logic [CntW-1:0]   cnt_q [NumBtn];
    logic [NumBtn-1:0] rise;

    state_e            state_d, state_q;
    logic [TimerW-1:0] timer_d, timer_q;
    logic              up_d, up_q;
    logic              down_d, down_q;
    logic              load_d, load_q;
    logic              repeating_d, repeating_q;

    assign raw       = {bus.btn_load, bus.btn_down, bus.btn_up};
    assign sync1_d   = raw;
    assign sync2_d   = sync1_q;
    assign db_prev_d = db_q;

    // A level change is accepted on the DB_CYCLES-th consecutive differing sample.
    always_comb begin
        db_d = db_q;
        for (int i = 0; i < NumBtn; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == CntW'(DB_CYCLES - 1)) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CntW'(1);
                end
            end
        end
    end

    // A rise still counts only if the level is not being released in the same cycle.
    assign rise = db_q & ~db_prev_q & db_d;

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        up_d        = 1'b0;
        down_d      = 1'b0;
        load_d      = 1'b0;
        repeating_d = repeating_q;

        unique case (state_q)
            StIdle: begin
                repeating_d = 1'b0;
                if (db_q[BtnUp] && db_q[BtnDown]) begin
                    state_d = StLock;
                end else if (rise[BtnUp]) begin
                    up_d    = 1'b1;
                    state_d = StHoldUp;
                    timer_d = TimerW'(HOLD_CYCLES);
                end else if (rise[BtnDown]) begin
                    down_d  = 1'b1;
                    state_d = StHoldDown;
                    timer_d = TimerW'(HOLD_CYCLES);
                end
            end
            StHoldUp: begin
                if (!db_d[BtnUp]) begin
                    state_d     = StIdle;
                    repeating_d = 1'b0;
                end else if (db_q[BtnDown]) begin
                    state_d     = StLock;
                    repeating_d = 1'b0;
                end else if (timer_q == TimerW'(1)) begin
                    up_d        = 1'b1;
                    timer_d     = TimerW'(REPEAT_CYCLES);
                    repeating_d = 1'b1;
                end else if (timer_q != '0) begin
                    timer_d = timer_q - TimerW'(1);
                end
            end
            StHoldDown: begin
                if (!db_d[BtnDown]) begin
                    state_d     = StIdle;
                    repeating_d = 1'b0;
                end else if (db_q[BtnUp]) begin
                    state_d     = StLock;
                    repeating_d = 1'b0;
                end else if (timer_q == TimerW'(1)) begin
                    down_d      = 1'b1;
                    timer_d     = TimerW'(REPEAT_CYCLES);
                    repeating_d = 1'b1;
                end else if (timer_q != '0) begin
                    timer_d = timer_q - TimerW'(1);
                end
            end
            StLock: begin
                repeating_d = 1'b0;
                if (!db_q[BtnUp] && !db_q[BtnDown]) begin
                    state_d = StIdle;
                end
            end
        endcase

        // Load overrides everything; a still-held direction must be re-pressed.
        if (rise[BtnLoad]) begin
            load_d      = 1'b1;
            up_d        = 1'b0;
            down_d      = 1'b0;
            repeating_d = 1'b0;
            state_d     = (db_q[BtnUp] || db_q[BtnDown]) ? StLock : StIdle;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            db_q        <= '0;
            db_prev_q   <= '0;
            for (int i = 0; i < NumBtn; i++) begin
                cnt_q[i] <= '0;
            end
            state_q     <= StIdle;
            timer_q     <= '0;
            up_q        <= 1'b0;
            down_q      <= 1'b0;
            load_q      <= 1'b0;
            repeating_q <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            db_q        <= db_d;
            db_prev_q   <= db_prev_d;
            for (int i = 0; i < NumBtn; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            state_q     <= state_d;
            timer_q     <= timer_d;
            up_q        <= up_d;
            down_q      <= down_d;
            load_q      <= load_d;
            repeating_q <= repeating_d;
        end
    end

    assign bus.up        = up_q;
    assign bus.down      = down_q;
    assign bus.load      = load_q;
    assign bus.repeating = repeating_q;

    cmd_onehot_a: assert property (@(posedge clk) disable iff (!reset)
        $onehot0({up_q, down_q, load_q}));

endmodule

// File: tb/tb_button_step_gen.sv
// Directed bench for button_step_gen: per-edge output logs compared against
// hand-computed pulse positions (edge 1 = first edge sampling the new input).
module tb_button_step_gen;

    logic clk = 1'b0;
    logic reset;

    button_step_gen_if bus ();

    button_step_gen #(
        .DB_CYCLES    (4),
        .HOLD_CYCLES  (10),
        .REPEAT_CYCLES(3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    logic [127:0] m_up, m_dn, m_ld, m_rep;
    logic [127:0] exp_up, exp_dn, exp_ld, exp_rep;

    task automatic clear_log();
        edge_n = 0;
        m_up   = '0;
        m_dn   = '0;
        m_ld   = '0;
        m_rep  = '0;
        exp_up  = '0;
        exp_dn  = '0;
        exp_ld  = '0;
        exp_rep = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
        if (edge_n < 128) begin
            m_up[edge_n]  = bus.up;
            m_dn[edge_n]  = bus.down;
            m_ld[edge_n]  = bus.load;
            m_rep[edge_n] = bus.repeating;
        end
    endtask

    // Each button is high for the edges in [from, to]; 0,0 means never pressed.
    task automatic drive_window(input int n, input int uf, input int ut, input int df,
                                input int dt, input int lf, input int lt);
        for (int k = 0; k < n; k++) begin
            int nx;
            nx = edge_n + 1;
            bus.btn_up   = (nx >= uf && nx <= ut);
            bus.btn_down = (nx >= df && nx <= dt);
            bus.btn_load = (nx >= lf && nx <= lt);
            tick();
        end
    endtask

    task automatic settle();
        drive_window(20, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        reset        = 1'b0;
        bus.btn_up   = 1'b0;
        bus.btn_down = 1'b0;
        bus.btn_load = 1'b0;
        #3;
        checks++;
        if (bus.up !== 1'b0) begin
            $display("FAIL reset_up: got %b want 0", bus.up);
            errors++;
        end
        checks++;
        if (bus.down !== 1'b0) begin
            $display("FAIL reset_down: got %b want 0", bus.down);
            errors++;
        end
        checks++;
        if (bus.load !== 1'b0) begin
            $display("FAIL reset_load: got %b want 0", bus.load);
            errors++;
        end
        checks++;
        if (bus.repeating !== 1'b0) begin
            $display("FAIL reset_repeating: got %b want 0", bus.repeating);
            errors++;
        end
        @(posedge clk);
        #3;
        reset = 1'b1;
        clear_log();
        drive_window(10, 0, 0, 0, 0, 0, 0);
        checks++;
        if ((m_up | m_dn | m_ld | m_rep) !== 128'd0) begin
            $display("FAIL reset_quiet: got %h want 0", m_up | m_dn | m_ld | m_rep);
            errors++;
        end
    endtask

    task automatic test_single_press();
        clear_log();
        drive_window(40, 1, 20, 0, 0, 0, 0);
        exp_up[7]  = 1'b1;
        exp_up[17] = 1'b1;
        exp_up[20] = 1'b1;
        exp_up[23] = 1'b1;
        for (int e = 17; e <= 25; e++) exp_rep[e] = 1'b1;
        checks++;
        if (m_up !== exp_up) begin
            $display("FAIL single_up: got %h want %h", m_up, exp_up);
            errors++;
        end
        checks++;
        if (m_rep !== exp_rep) begin
            $display("FAIL single_repeating: got %h want %h", m_rep, exp_rep);
            errors++;
        end
        checks++;
        if ((m_dn | m_ld) !== 128'd0) begin
            $display("FAIL single_other: got %h want 0", m_dn | m_ld);
            errors++;
        end
    endtask

    task automatic test_bounce();
        clear_log();
        for (int k = 0; k < 40; k++) begin
            int nx;
            nx = edge_n + 1;
            bus.btn_up   = 1'b0;
            bus.btn_load = 1'b0;
            if (nx <= 12) bus.btn_down = (((nx - 1) % 4) < 2);
            else          bus.btn_down = (nx <= 20);
            tick();
        end
        exp_dn[19] = 1'b1;
        checks++;
        if (m_dn !== exp_dn) begin
            $display("FAIL bounce_down: got %h want %h", m_dn, exp_dn);
            errors++;
        end
        checks++;
        if ((m_up | m_ld | m_rep) !== 128'd0) begin
            $display("FAIL bounce_other: got %h want 0", m_up | m_ld | m_rep);
            errors++;
        end
    endtask

    task automatic test_long_hold();
        clear_log();
        drive_window(60, 1, 40, 0, 0, 0, 0);
        exp_up[7] = 1'b1;
        for (int e = 17; e <= 44; e += 3) exp_up[e] = 1'b1;
        for (int e = 17; e <= 45; e++) exp_rep[e] = 1'b1;
        checks++;
        if (m_up !== exp_up) begin
            $display("FAIL long_up: got %h want %h", m_up, exp_up);
            errors++;
        end
        checks++;
        if (m_rep !== exp_rep) begin
            $display("FAIL long_repeating: got %h want %h", m_rep, exp_rep);
            errors++;
        end
        checks++;
        if (m_dn !== 128'd0) begin
            $display("FAIL long_down: got %h want 0", m_dn);
            errors++;
        end
    endtask

    task automatic test_conflict();
        clear_log();
        drive_window(55, 1, 35, 22, 35, 0, 0);
        exp_up[7]  = 1'b1;
        exp_up[17] = 1'b1;
        exp_up[20] = 1'b1;
        exp_up[23] = 1'b1;
        exp_up[26] = 1'b1;
        for (int e = 17; e <= 27; e++) exp_rep[e] = 1'b1;
        checks++;
        if (m_up !== exp_up) begin
            $display("FAIL conflict_up: got %h want %h", m_up, exp_up);
            errors++;
        end
        checks++;
        if (m_dn !== 128'd0) begin
            $display("FAIL conflict_down: got %h want 0", m_dn);
            errors++;
        end
        checks++;
        if (m_rep !== exp_rep) begin
            $display("FAIL conflict_repeating: got %h want %h", m_rep, exp_rep);
            errors++;
        end
        clear_log();
        drive_window(30, 0, 0, 1, 10, 0, 0);
        exp_dn[7] = 1'b1;
        checks++;
        if (m_dn !== exp_dn) begin
            $display("FAIL conflict_single_down: got %h want %h", m_dn, exp_dn);
            errors++;
        end
        checks++;
        if ((m_up | m_ld) !== 128'd0) begin
            $display("FAIL conflict_single_other: got %h want 0", m_up | m_ld);
            errors++;
        end
    endtask

    task automatic test_load_priority();
        clear_log();
        drive_window(60, 1, 45, 0, 0, 23, 31);
        exp_up[7]  = 1'b1;
        exp_up[17] = 1'b1;
        exp_up[20] = 1'b1;
        exp_up[23] = 1'b1;
        exp_up[26] = 1'b1;
        exp_ld[29] = 1'b1;
        for (int e = 17; e <= 28; e++) exp_rep[e] = 1'b1;
        checks++;
        if (m_up !== exp_up) begin
            $display("FAIL load_up: got %h want %h", m_up, exp_up);
            errors++;
        end
        checks++;
        if (m_ld !== exp_ld) begin
            $display("FAIL load_pulse: got %h want %h", m_ld, exp_ld);
            errors++;
        end
        checks++;
        if (m_rep !== exp_rep) begin
            $display("FAIL load_repeating: got %h want %h", m_rep, exp_rep);
            errors++;
        end
        clear_log();
        drive_window(25, 1, 8, 0, 0, 0, 0);
        exp_up[7] = 1'b1;
        checks++;
        if (m_up !== exp_up) begin
            $display("FAIL load_repress_up: got %h want %h", m_up, exp_up);
            errors++;
        end
        checks++;
        if ((m_dn | m_ld) !== 128'd0) begin
            $display("FAIL load_repress_other: got %h want 0", m_dn | m_ld);
            errors++;
        end
    endtask

    task automatic test_reset_mid_hold();
        clear_log();
        drive_window(17, 1, 100, 0, 0, 0, 0);
        checks++;
        if ({bus.up, bus.repeating} !== 2'b11) begin
            $display("FAIL midhold_pre: got %b want 11", {bus.up, bus.repeating});
            errors++;
        end
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if ({bus.up, bus.down, bus.load, bus.repeating} !== 4'b0000) begin
            $display("FAIL midhold_async_clear: got %b want 0000",
                     {bus.up, bus.down, bus.load, bus.repeating});
            errors++;
        end
        @(posedge clk);
        #3;
        reset = 1'b1;
        clear_log();
        drive_window(14, 1, 100, 0, 0, 0, 0);
        exp_up[7] = 1'b1;
        checks++;
        if (m_up !== exp_up) begin
            $display("FAIL midhold_fresh_up: got %h want %h", m_up, exp_up);
            errors++;
        end
        checks++;
        if ((m_rep | m_dn | m_ld) !== 128'd0) begin
            $display("FAIL midhold_fresh_other: got %h want 0", m_rep | m_dn | m_ld);
            errors++;
        end
        settle();
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_long_hold();
        test_conflict();
        test_load_priority();
        test_reset_mid_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
